// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive-side scheduler.
//   rx_sched_st_e : receive FSM states
//   rx_entry_t    : one buffered frame (status bits plus received byte)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        BITS,
        PUSH,
        BREAK_WAIT
    } rx_sched_st_e;

    typedef struct packed {
        logic                 perr;
        logic                 ferr;
        logic [DATA_BITS-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous DEPTH x rx_entry_t FIFO. The head entry is presented directly
// from storage, so a push becomes visible one clock later (no bypass).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_entry (ignored when full unless popping the same cycle)
//   i_entry    : entry to write
//   i_pop      : remove the head entry (ignored when empty)
//   o_head     : head entry, all zero while empty
//   o_full     : no free slot
//   o_empty    : no stored entry
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_push,
    input  rx_entry_t i_entry,
    input  logic      i_pop,
    output rx_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int AW = $clog2(DEPTH);

    rx_entry_t       r_mem [DEPTH];
    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    logic            w_do_pop;
    logic            w_do_push;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: the storage array has no reset; only the pointers do, and the head
    // is masked to zero while empty so stale contents never reach the outputs.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    assign o_head = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_sched.sv
// -----------------------------------------------------------------------------
// uart_rx_sched
// Receive-side UART controller: synchronises the raw line, qualifies the start
// bit, issues mid-bit baud_trig pulses to the datapath, checks parity and stop
// bit, and buffers {perr, ferr, byte} frames in a FIFO with valid/ready output.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   rx_in        : raw asynchronous serial line
//   baud_trig    : one-cycle pulse at each bit centre
//   rx_done      : datapath frame-complete pulse, rx_data valid with it
//   rx_data      : datapath byte
//   out_valid    : FIFO head valid
//   out_ready    : consumer accepts head
//   out_data     : head byte
//   out_perr     : head parity error
//   out_ferr     : head framing error
//   ovr_flag     : sticky overrun (frame dropped on full FIFO)
//   clr_err      : clears ovr_flag
//   busy         : frame in progress
// -----------------------------------------------------------------------------
module uart_rx_sched
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 54,
    parameter int OVS     = 16,
    parameter int DEPTH   = 4,
    parameter int PAR_EN  = 1,
    parameter int PAR_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic       baud_trig,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_perr,
    output logic       out_ferr,
    output logic       ovr_flag,
    input  logic       clr_err,
    output logic       busy
);

    localparam int NB = 10 + PAR_EN;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW = $clog2(OVS);

    localparam logic [PW-1:0] PRESC_MAX   = PW'(CLK_DIV - 1);
    localparam logic [TW-1:0] HALF_MAX    = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] BIT_MAX     = TW'(OVS - 1);
    localparam logic [3:0]    LAST_IDX    = 4'(NB - 1);
    localparam logic [3:0]    PAR_IDX     = 4'(DATA_BITS + 1);
    localparam logic          PAR_ENABLE  = (PAR_EN != 0);
    localparam logic          PAR_ODD_BIT = (PAR_ODD != 0);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rxs;
    rx_sched_st_e         r_state;
    logic [PW-1:0]        r_presc;
    logic                 w_os_tick;
    logic [TW-1:0]        r_tick_cnt;
    logic [3:0]           r_bit_idx;
    logic [3:0]           w_next_idx;
    logic                 r_par_bit;
    logic                 r_stop_bit;
    logic                 r_baud_trig;
    logic [7:0]           r_hold;
    logic                 r_hold_v;
    logic                 r_ovr_flag;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_ovr;
    logic [7:0]           w_data;
    rx_entry_t            w_entry;
    rx_entry_t            w_head;

    // Two-flop synchroniser; idles high like the line itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end
    assign w_rxs = r_sync2;

    // Held at zero in IDLE so the oversample phase starts with the frame.
    assign w_os_tick = (r_state != IDLE) && (r_presc == PRESC_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (r_state == IDLE || w_os_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_next_idx = r_bit_idx + 4'd1;

    // NOTE: every state register here uses non-blocking assignment so all of
    // them update from the same pre-edge values; blocking would create order
    // dependence between statements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tick_cnt  <= '0;
            r_bit_idx   <= '0;
            r_par_bit   <= 1'b0;
            r_stop_bit  <= 1'b0;
            r_baud_trig <= 1'b0;
        end else begin
            r_baud_trig <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        r_state    <= START_CHK;
                        r_tick_cnt <= '0;
                        r_bit_idx  <= '0;
                    end
                end
                START_CHK: begin
                    if (w_os_tick) begin
                        if (r_tick_cnt == HALF_MAX) begin
                            // Still low at mid start bit: a real start; otherwise a glitch.
                            if (!w_rxs) begin
                                r_baud_trig <= 1'b1;
                                r_state     <= BITS;
                                r_tick_cnt  <= '0;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                BITS: begin
                    if (w_os_tick) begin
                        if (r_tick_cnt == BIT_MAX) begin
                            r_tick_cnt  <= '0;
                            r_baud_trig <= 1'b1;
                            r_bit_idx   <= w_next_idx;
                            if (PAR_ENABLE && w_next_idx == PAR_IDX) begin
                                r_par_bit <= w_rxs;
                            end
                            if (w_next_idx == LAST_IDX) begin
                                r_stop_bit <= w_rxs;
                                r_state    <= PUSH;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                PUSH: begin
                    // A low stop bit may be a break; wait for the line to recover.
                    r_state <= (r_stop_bit == STOP_LEVEL) ? IDLE : BREAK_WAIT;
                end
                BREAK_WAIT: begin
                    if (w_rxs) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Datapath byte holding register. A rx_done coinciding with PUSH belongs to
    // the next frame, so the capture takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold   <= 8'h00;
            r_hold_v <= 1'b0;
        end else if (rx_done) begin
            r_hold   <= rx_data;
            r_hold_v <= 1'b1;
        end else if (r_state == PUSH) begin
            r_hold_v <= 1'b0;
        end
    end

    assign w_data = r_hold_v ? r_hold : 8'hFF;

    // NOTE: every field gets an unconditional assignment, so no latch is inferred.
    always_comb begin
        w_entry      = '0;
        w_entry.data = w_data;
        // Missing datapath byte counts as a framing error as well.
        w_entry.ferr = (r_stop_bit != STOP_LEVEL) || !r_hold_v;
        w_entry.perr = PAR_ENABLE && ((^w_data) ^ r_par_bit ^ PAR_ODD_BIT);
    end

    assign w_push = (r_state == PUSH);
    assign w_pop  = out_valid && out_ready;
    assign w_ovr  = w_push && w_full && !w_pop;

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Sticky overrun; a new overrun beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr_flag <= 1'b0;
        end else if (w_ovr) begin
            r_ovr_flag <= 1'b1;
        end else if (clr_err) begin
            r_ovr_flag <= 1'b0;
        end
    end

    assign baud_trig = r_baud_trig;
    assign out_valid = !w_empty;
    assign out_data  = w_head.data;
    assign out_perr  = w_head.perr;
    assign out_ferr  = w_head.ferr;
    assign ovr_flag  = r_ovr_flag;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_sched
// Directed frames on rx_in with a datapath stand-in driving rx_done/rx_data.
// Expected FIFO entries are queued when a frame is sent; a monitor pops and
// compares on every out_valid && out_ready handshake.
// -----------------------------------------------------------------------------
module tb_uart_rx_sched;

    localparam int CLK_DIV = 8;
    localparam int OVS     = 16;
    localparam int DEPTH   = 4;
    localparam int PAR_EN  = 1;
    localparam int PAR_ODD = 0;
    localparam int BIT_CLK = CLK_DIV * OVS;
    localparam int NB      = 10 + PAR_EN;

    typedef struct packed {
        logic       perr;
        logic       ferr;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic       baud_trig;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_perr;
    logic       out_ferr;
    logic       ovr_flag;
    logic       clr_err = 1'b0;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   gaps[$];
    int   trig_total = 0;
    int   trig_base  = 0;
    int   cyc        = 0;
    int   last_trig  = 0;

    uart_rx_sched #(
        .CLK_DIV (CLK_DIV),
        .OVS     (OVS),
        .DEPTH   (DEPTH),
        .PAR_EN  (PAR_EN),
        .PAR_ODD (PAR_ODD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_in     (rx_in),
        .baud_trig (baud_trig),
        .rx_done   (rx_done),
        .rx_data   (rx_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_perr  (out_perr),
        .out_ferr  (out_ferr),
        .ovr_flag  (ovr_flag),
        .clr_err   (clr_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // baud_trig monitor: records the clock gap before every pulse.
    always @(negedge clk) begin
        if (baud_trig) begin
            gaps.push_back(cyc - last_trig);
            last_trig = cyc;
            trig_total++;
        end
    end

    // Scoreboard monitor: one comparison per accepted head entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_entry got=%0h exp=none at %0t",
                         {out_perr, out_ferr, out_data}, $time);
            end else begin
                e = sb.pop_front();
                check("entry", {22'd0, out_perr, out_ferr, out_data}, {22'd0, e});
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (BIT_CLK) tick();
    endtask

    task automatic check_trigs(input int exp_n);
        int bad;
        bad = 0;
        check("trig_count", trig_total - trig_base, exp_n);
        for (int i = 1; i < gaps.size(); i++) begin
            if (gaps[i] != BIT_CLK) bad++;
        end
        check("trig_spacing_bad", bad, 0);
    endtask

    // Sends one frame; the datapath stand-in pulses rx_done with d during the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input logic chk_lat);
        int   n;
        logic prev_v;
        trig_base = trig_total;
        gaps.delete();
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN != 0) drive_bit(par);
        rx_in = stop;
        repeat (BIT_CLK / 4) tick();
        rx_done = 1'b1;
        rx_data = d;
        tick();
        rx_done = 1'b0;
        rx_data = 8'h00;
        if (stop) begin
            prev_v = 1'b0;
            n = 0;
            @(negedge clk);
            while (busy && n < BIT_CLK) begin
                prev_v = out_valid;
                n++;
                @(negedge clk);
            end
            check("frame_end_busy", busy, 0);
            if (chk_lat) begin
                check("valid_during_push", prev_v, 0);
                check("valid_after_push", out_valid, 1);
            end
            tick();
            repeat (BIT_CLK / 2) tick();
            check_trigs(NB);
        end else begin
            repeat (BIT_CLK - BIT_CLK / 4 - 1) tick();
        end
    endtask

    initial begin
        logic par_tab [5];
        par_tab = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};   // even parity of 01..05

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_baud_trig", baud_trig, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_perr", out_perr, 0);
        check("rst_out_ferr", out_ferr, 0);
        check("rst_ovr_flag", ovr_flag, 0);
        check("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();

        // Good A5 frame, even parity bit 0
        out_ready = 1'b1;
        sb.push_back('{perr: 1'b0, ferr: 1'b0, data: 8'hA5});
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);

        // Parity bit flipped
        sb.push_back('{perr: 1'b1, ferr: 1'b0, data: 8'hA5});
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);

        // Low stop bit followed by 3 bit times of break
        sb.push_back('{perr: 1'b0, ferr: 1'b1, data: 8'h3C});
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (3 * BIT_CLK) tick();
        @(negedge clk);
        check("break_busy", busy, 1);
        check_trigs(NB);
        tick();
        rx_in = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("break_release_busy", busy, 0);
        tick();
        repeat (BIT_CLK) tick();

        // 5 os_tick low glitch
        trig_base = trig_total;
        rx_in = 1'b0;
        repeat (5 * CLK_DIV) tick();
        @(negedge clk);
        check("glitch_seen_busy", busy, 1);
        tick();
        rx_in = 1'b1;
        repeat (BIT_CLK) tick();
        @(negedge clk);
        check("glitch_trigs", trig_total - trig_base, 0);
        check("glitch_busy", busy, 0);
        check("glitch_no_push", out_valid, 0);
        tick();

        // Five frames into a 4-deep FIFO with no consumer
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < DEPTH) sb.push_back('{perr: 1'b0, ferr: 1'b0, data: 8'(i + 1)});
            send_frame(8'(i + 1), par_tab[i], 1'b1, i == 0);
        end
        @(negedge clk);
        check("ovr_set", ovr_flag, 1);
        check("ovr_head_valid", out_valid, 1);
        check("ovr_head_data", out_data, 8'h01);
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        @(negedge clk);
        check("ovr_cleared", ovr_flag, 0);
        tick();
        out_ready = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        check("drain_left", sb.size(), 0);
        check("drain_valid", out_valid, 0);
        tick();

        // Reset in the middle of frame 2, frame 1 stored
        out_ready = 1'b0;
        sb.push_back('{perr: 1'b0, ferr: 1'b0, data: 8'h5A});
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rx_in = 1'b0;
        repeat (BIT_CLK / 2) tick();
        check("pre_reset_busy", busy, 1);
        check("pre_reset_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_baud_trig", baud_trig, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 8'h00);
        check("mid_rst_out_perr", out_perr, 0);
        check("mid_rst_out_ferr", out_ferr, 0);
        check("mid_rst_ovr_flag", ovr_flag, 0);
        check("mid_rst_busy", busy, 0);
        sb.delete();
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (BIT_CLK) tick();
        @(negedge clk);
        check("post_rst_valid", out_valid, 0);
        tick();

        // Clean frame after reset
        out_ready = 1'b1;
        sb.push_back('{perr: 1'b0, ferr: 1'b0, data: 8'h96});
        send_frame(8'h96, 1'b0, 1'b1, 1'b1);
        repeat (10) tick();
        @(negedge clk);
        check("final_left", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
